// File: rtl/key_expand_ctrl.sv
// AES-128 key expansion sequencer with indexed round-key bank.
// One round key per cycle; keys are read back through a registered port.
module key_schedule (
  input  logic [127:0] key_i,
  input  logic [7:0]   round_num,
  input  logic         enc_or_dec_i,
  output logic [127:0] key_r
);

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8); 0 maps to 0
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x12  = gmul(gmul(x3, x3), gmul(x3, x3));
    x15  = gmul(x12, x3);
    x240 = gmul(x15, x15);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    return gmul(gmul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] rotl(
    input logic [7:0] x,
    input int         n
  );
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(
    input logic [7:0] x,
    input logic       inv
  );
    logic [7:0] a;
    if (inv) begin
      a = rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05;
      return ginv(a);
    end
    a = ginv(x);
    return a ^ rotl(a, 1) ^ rotl(a, 2)
             ^ rotl(a, 3) ^ rotl(a, 4) ^ 8'h63;
  endfunction

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rw, sw, t;
  logic [31:0] n0, n1, n2, n3;
  logic [7:0]  rcon;

  // round constant lookup; round 0 never issued
  always_comb begin
    rcon = 8'h00;
    unique case (round_num)
      8'd1:    rcon = 8'h01;
      8'd2:    rcon = 8'h02;
      8'd3:    rcon = 8'h04;
      8'd4:    rcon = 8'h08;
      8'd5:    rcon = 8'h10;
      8'd6:    rcon = 8'h20;
      8'd7:    rcon = 8'h40;
      8'd8:    rcon = 8'h80;
      8'd9:    rcon = 8'h1b;
      8'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // one round of the word recurrence
  always_comb begin
    {w0, w1, w2, w3} = key_i;
    rw = {w3[23:0], w3[31:24]};
    sw = {sbox(rw[31:24], enc_or_dec_i),
          sbox(rw[23:16], enc_or_dec_i),
          sbox(rw[15:8],  enc_or_dec_i),
          sbox(rw[7:0],   enc_or_dec_i)};
    t  = sw ^ {rcon, 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    key_r = {n0, n1, n2, n3};
  end

endmodule

module key_expand_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_W      = 128
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [KEY_W-1:0] key_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             keys_vld_o,
  input  logic [3:0]       rk_idx_i,
  output logic [KEY_W-1:0] rk_o,
  output logic             rk_vld_o
);

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic             done_q;
  logic             load, step, last;
  logic [KEY_W-1:0] work_q;
  logic [KEY_W-1:0] key_r;
  logic [KEY_W-1:0] rk_q;
  logic             rk_vld_q;
  logic             rd_ok;
  logic [KEY_W-1:0] bank [0:NUM_ROUNDS];

  key_schedule u_ks (
    .key_i        (work_q),
    .round_num    ({4'b0, cnt_q}),
    .enc_or_dec_i (1'b0),
    .key_r        (key_r)
  );

  // next state, counter and valid flag
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = EXPAND;
          cnt_d   = 4'd1;
          vld_d   = 1'b0;
          load    = 1'b1;
        end
      end
      EXPAND: begin
        step  = 1'b1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST) begin
          last    = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
          vld_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // control state and working key
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      done_q  <= last;
      if (load)      work_q <= key_i;
      else if (step) work_q <= key_r;
    end
  end

  // round-key bank; contents survive reset, masked by vld_q
  always_ff @(posedge clk_i) begin
    if (load)      bank[0]     <= key_i;
    else if (step) bank[cnt_q] <= key_r;
  end

  assign rd_ok = int'(rk_idx_i) <= NUM_ROUNDS;

  // registered read port, no write bypass
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rk_q     <= '0;
      rk_vld_q <= 1'b0;
    end else begin
      rk_q     <= rd_ok ? bank[rk_idx_i] : '0;
      rk_vld_q <= rd_ok && vld_q;
    end
  end

  assign busy_o     = (state_q == EXPAND);
  assign done_o     = done_q;
  assign keys_vld_o = vld_q;
  assign rk_o       = rk_q;
  assign rk_vld_o   = rk_vld_q;

endmodule

// File: tb/tb_key_expand_ctrl.sv
// Bench for key_expand_ctrl: known-answer round keys,
// read-port scoreboard, start/restart and reset handling.
module tb_key_expand_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key;
  logic         busy, done, keys_vld;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         rk_vld;

  always #5 clk = ~clk;

  key_expand_ctrl dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .start_i    (start),
    .key_i      (key),
    .busy_o     (busy),
    .done_o     (done),
    .keys_vld_o (keys_vld),
    .rk_idx_i   (rk_idx),
    .rk_o       (rk),
    .rk_vld_o   (rk_vld)
  );

  localparam logic [127:0] FK [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [127:0] ZK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] AK0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] AK1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] AK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  typedef struct {
    logic [127:0] rk;
    logic         vld;
    logic [3:0]   idx;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // issue a read at a falling edge; result expected after the next rise
  task automatic rd(
    input logic [3:0]   idx,
    input logic [127:0] erk,
    input logic         evld
  );
    exp_t e;
    e.rk  = erk;
    e.vld = evld;
    e.idx = idx;
    rk_idx = idx;
    sb.push_back(e);
  endtask

  always begin
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      chk($sformatf("rk[%0d]", cur.idx), rk, cur.rk);
      chk($sformatf("rk_vld[%0d]", cur.idx), {127'b0, rk_vld},
          {127'b0, cur.vld});
    end
  end

  // caller raised start at this falling edge; returns negedges to done
  task automatic wait_done(output int k);
    k = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      k++;
    end while (!done && k < 40);
    chk("done_seen", {127'b0, done}, 128'd1);
  endtask

  task automatic read_all_fips();
    for (int i = 0; i <= 10; i++) begin
      rd(4'(i), FK[i], 1'b1);
      @(negedge clk);
    end
  endtask

  int k;
  int first;
  int ndone;

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    key    = '0;
    rk_idx = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {127'b0, busy}, 128'd0);
    chk("rst_done", {127'b0, done}, 128'd0);
    chk("rst_kvld", {127'b0, keys_vld}, 128'd0);
    chk("rst_rk", rk, 128'd0);
    chk("rst_rkvld", {127'b0, rk_vld}, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS key, reads of idx0 while expanding
    start = 1'b1;
    key   = FK[0];
    k     = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      k++;
      if (k == 1) chk("busy_on", {127'b0, busy}, 128'd1);
      if (!done && k <= 10) rd(4'd0, FK[0], 1'b0);
    end while (!done && k < 40);
    chk("fips_lat", 128'(k), 128'd11);
    chk("fips_kvld", {127'b0, keys_vld}, 128'd1);
    @(negedge clk);
    chk("done_pulse", {127'b0, done}, 128'd0);
    chk("busy_off", {127'b0, busy}, 128'd0);
    read_all_fips();
    rd(4'd11, 128'd0, 1'b0);
    @(negedge clk);
    rd(4'd15, 128'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);

    // start held 20 cycles, key changes at cycle 3
    start = 1'b1;
    key   = '0;
    first = 0;
    ndone = 0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c == 3) key = FK[0];
      if (c == 20) start = 1'b0;
      if (done) begin
        ndone++;
        if (first == 0) first = c;
      end
      if (c == 11) rd(4'd1, ZK1, 1'b1);
      if (c == 12) begin
        chk("restart_busy", {127'b0, busy}, 128'd1);
        chk("restart_kvld", {127'b0, keys_vld}, 128'd0);
      end
      if (c == 22) chk("done2", {127'b0, done}, 128'd1);
    end
    chk("hold_first", 128'(first), 128'd11);
    chk("hold_ndone", 128'(ndone), 128'd2);
    rd(4'd1, FK[1], 1'b1);
    @(negedge clk);
    rd(4'd10, FK[10], 1'b1);
    @(negedge clk);
    @(negedge clk);

    // reset in the middle of an expansion
    start = 1'b1;
    key   = '0;
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("mid_busy", {127'b0, busy}, 128'd0);
    chk("mid_done", {127'b0, done}, 128'd0);
    chk("mid_kvld", {127'b0, keys_vld}, 128'd0);
    chk("mid_rk", rk, 128'd0);
    chk("mid_rkvld", {127'b0, rk_vld}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(4'd0, 128'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    key   = '0;
    wait_done(k);
    chk("zero_lat", 128'(k), 128'd11);
    @(negedge clk);
    rd(4'd1, ZK1, 1'b1);
    @(negedge clk);
    rd(4'd10, ZK10, 1'b1);
    @(negedge clk);
    @(negedge clk);

    // back-to-back: key A then FIPS on the done cycle
    start = 1'b1;
    key   = AK0;
    wait_done(k);
    chk("a_lat", 128'(k), 128'd11);
    start = 1'b1;
    key   = FK[0];
    rd(4'd1, AK1, 1'b1);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) rd(4'd1, AK1, 1'b0);
      if (c == 2) rd(4'd10, AK10, 1'b0);
      if (c <= 10) begin
        chk($sformatf("b2b_kvld%0d", c), {127'b0, keys_vld}, 128'd0);
      end else begin
        chk("b2b_done", {127'b0, done}, 128'd1);
        chk("b2b_kvld", {127'b0, keys_vld}, 128'd1);
      end
    end
    read_all_fips();
    @(negedge clk);
    @(negedge clk);

    if (sb.size() != 0) chk("sb_drain", 128'(sb.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
